// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind a UART receiver: finds SYNC/LEN/payload/CHK frames, checks the
// XOR checksum and streams accepted payloads out on a valid/ready port with a last flag.
module uart_rx_frame_parser #(
   parameter int          MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic [7:0] m_data_o,
   output logic       m_valid_o,
   input  logic       m_ready_i,
   output logic       m_last_o,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [1:0] err_code_o,
   output logic       busy_o
);

   // Output stream handshake: a byte moves on a clock edge where m_valid_o and m_ready_i
   // are both high; while m_ready_i is low, m_data_o and m_last_o stay unchanged.
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES >= 65536) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
   localparam logic [TMO_W-1:0] TMO_LIM =
      TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [1:0] ERR_TMO = 2'd0;
   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_CHK = 2'd2;
   localparam logic [1:0] ERR_OVR = 2'd3;

   typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [7:0]         len_m1_q;
   logic [7:0]         acc_q;
   logic [IDX_W-1:0]   wr_idx_q;
   logic [IDX_W-1:0]   rd_idx_q;
   logic [TMO_W-1:0]   tmo_cnt_q;
   logic [7:0]         buf_q [MAX_LEN];
   logic               frame_ok_q, frame_err_q;
   logic [1:0]         err_code_q;

   logic               len_bad, wr_last, rd_last, tmo_hit, tmo_active;
   logic               ok_set, err_set;
   logic [1:0]         err_code_d;

   assign len_bad    = (rx_data_i == 8'd0) || (rx_data_i > MAX_LEN_B);
   assign wr_last    = (8'(wr_idx_q) == len_m1_q);
   assign rd_last    = (8'(rd_idx_q) == len_m1_q);
   assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LIM);
   assign tmo_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_SYNC;
      else       state_q <= state_d;
   end

   // A byte on the same cycle as timeout expiry always takes priority.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC:    if (rx_valid_i && rx_data_i == SYNC_BYTE) state_d = S_LEN;
         S_LEN:     if (rx_valid_i) state_d = len_bad ? S_SYNC : S_PAYLOAD;
                    else if (tmo_hit) state_d = S_SYNC;
         S_PAYLOAD: if (rx_valid_i) begin
                       if (wr_last) state_d = S_CHK;
                    end else if (tmo_hit) state_d = S_SYNC;
         S_CHK:     if (rx_valid_i) state_d = (rx_data_i == acc_q) ? S_DRAIN : S_SYNC;
                    else if (tmo_hit) state_d = S_SYNC;
         S_DRAIN:   if (m_ready_i && rd_last) state_d = S_SYNC;
         default:   state_d = S_SYNC;
      endcase
   end

   always_comb begin
      ok_set     = 1'b0;
      err_set    = 1'b0;
      err_code_d = err_code_q;
      case (state_q)
         S_LEN:     if (rx_valid_i) begin
                       if (len_bad) begin err_set = 1'b1; err_code_d = ERR_LEN; end
                    end else if (tmo_hit) begin err_set = 1'b1; err_code_d = ERR_TMO; end
         S_PAYLOAD: if (!rx_valid_i && tmo_hit) begin err_set = 1'b1; err_code_d = ERR_TMO; end
         S_CHK:     if (rx_valid_i) begin
                       if (rx_data_i == acc_q) ok_set = 1'b1;
                       else begin err_set = 1'b1; err_code_d = ERR_CHK; end
                    end else if (tmo_hit) begin err_set = 1'b1; err_code_d = ERR_TMO; end
         S_DRAIN:   if (rx_valid_i) begin err_set = 1'b1; err_code_d = ERR_OVR; end
         default:   ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_m1_q    <= '0;
         acc_q       <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         tmo_cnt_q   <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
      end else begin
         frame_ok_q  <= ok_set;
         frame_err_q <= err_set;
         if (err_set) err_code_q <= err_code_d;
         if (tmo_active && !rx_valid_i) tmo_cnt_q <= tmo_cnt_q + 1'b1;
         else                           tmo_cnt_q <= '0;
         case (state_q)
            S_LEN:     if (rx_valid_i && !len_bad) begin
                          len_m1_q <= rx_data_i - 8'd1;
                          acc_q    <= rx_data_i;
                          wr_idx_q <= '0;
                       end
            S_PAYLOAD: if (rx_valid_i) begin
                          buf_q[wr_idx_q] <= rx_data_i;
                          acc_q           <= acc_q ^ rx_data_i;
                          wr_idx_q        <= wr_idx_q + 1'b1;
                       end
            S_CHK:     if (rx_valid_i && rx_data_i == acc_q) rd_idx_q <= '0;
            S_DRAIN:   if (m_ready_i) rd_idx_q <= rd_last ? '0 : rd_idx_q + 1'b1;
            default:   ;
         endcase
      end
   end

   assign m_data_o    = buf_q[rd_idx_q];
   assign m_valid_o   = (state_q == S_DRAIN);
   assign m_last_o    = (state_q == S_DRAIN) && rd_last;
   assign busy_o      = (state_q != S_SYNC);
   assign frame_ok_o  = frame_ok_q;
   assign frame_err_o = frame_err_q;
   assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: scripted frames, expected beats and error codes queued
// at send time and popped by a negedge monitor.
module tb_uart_rx_frame_parser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic       m_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   uart_rx_frame_parser #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(1000)) dut (
      .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
      .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last),
      .frame_ok_o(frame_ok), .frame_err_o(frame_err), .err_code_o(err_code), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [8:0] exp_q[$];
   logic [1:0] err_q[$];
   int ok_exp = 0, ok_seen = 0;
   int ready_mode = 0;
   int rcnt = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #2;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic exp_beat(input logic [7:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy && exp_q.size() == 0) break;
         @(posedge clk); #2;
      end
      check("idle_busy", busy, 0);
      check("idle_drained", exp_q.size(), 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // 0: ready always high, 1: pattern 1,0,0 repeating, 2: held low
   always begin
      @(posedge clk); #2;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       begin m_ready = (rcnt % 3 == 0); rcnt++; end
         default: m_ready = 1'b0;
      endcase
   end

   logic       hold_pending = 1'b0;
   logic [7:0] hold_data;
   logic       hold_last;
   logic       busy_chk = 1'b0;
   logic       in_frame = 1'b0;
   int         last_cyc = 0;
   logic [8:0] e;

   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
         in_frame     = 1'b0;
      end else begin
         if (hold_pending) begin
            check("hold_data", m_data, hold_data);
            check("hold_last", m_last, hold_last);
         end
         hold_pending = m_valid && !m_ready;
         hold_data    = m_data;
         hold_last    = m_last;
         if (busy_chk) begin
            check("busy_fall", busy, 0);
            busy_chk = 1'b0;
         end
         if (frame_ok) begin
            ok_seen++;
            check("ok_with_valid", m_valid, 1);
         end
         if (frame_err) begin
            if (err_q.size() == 0) check("unexp_err", err_q.size(), 1);
            else check("err_code", err_code, err_q.pop_front());
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("unexp_beat", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("beat", {m_last, m_data}, e);
               if (ready_mode == 0 && in_frame) check("beat_gap", cyc - last_cyc, 1);
               last_cyc = cyc;
               in_frame = !e[8];
               if (e[8]) busy_chk = 1'b1;
            end
         end
      end
   end

   int k;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", busy, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_ok", frame_ok, 0);
      check("rst_err", frame_err, 0);
      check("rst_code", err_code, 0);
      check("rst_data", m_data, 0);
      rst = 1'b0;
      idle(2);

      // basic frame, ready high
      ready_mode = 0;
      ok_exp++;
      exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      wait_idle();
      check("s1_ok_count", ok_seen, ok_exp);

      // same frame with stalling ready
      ready_mode = 1;
      ok_exp++;
      exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      wait_idle();
      check("s2_ok_count", ok_seen, ok_exp);

      // junk then bad checksum, then a one-byte frame
      ready_mode = 0;
      err_q.push_back(2'd2);
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFE);
      idle(3);
      check("s3_code", err_code, 2);
      check("s3_no_valid", m_valid, 0);
      ok_exp++;
      exp_beat(8'h5A, 1);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      wait_idle();

      // zero and oversize length, then sync value as payload
      err_q.push_back(2'd1); err_q.push_back(2'd1);
      send_byte(8'hA5); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h11);
      idle(2);
      check("s4_code", err_code, 1);
      check("s4_busy", busy, 0);
      ok_exp++;
      exp_beat(8'hA5, 1);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA4);
      wait_idle();

      // inter-byte timeout
      err_q.push_back(2'd0);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      k = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(posedge clk); #2;
         if (frame_err) begin k = i; break; end
      end
      check("tmo_delay", k, 1000);
      idle(2);
      check("tmo_code", err_code, 0);
      check("tmo_busy", busy, 0);
      ok_exp++;
      exp_beat(8'h3C, 1);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
      wait_idle();

      // overrun while draining with ready low
      ready_mode = 2;
      idle(1);
      ok_exp++;
      exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
      idle(2);
      check("ovr_valid_before", m_valid, 1);
      err_q.push_back(2'd3);
      send_byte(8'h77);
      idle(3);
      check("ovr_code", err_code, 3);
      check("ovr_valid_after", m_valid, 1);
      check("ovr_data", m_data, 8'h11);
      ready_mode = 0;
      wait_idle();

      // asynchronous reset mid-payload
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", m_valid, 0);
      check("arst_code", err_code, 0);
      check("arst_err", frame_err, 0);
      check("arst_data", m_data, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      idle(2);
      ok_exp++;
      exp_beat(8'h0F, 0); exp_beat(8'hF0, 1);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0F);
      send_byte(8'hF0); send_byte(8'hFD);
      wait_idle();
      idle(3);

      check("final_ok_count", ok_seen, ok_exp);
      check("final_beats_left", exp_q.size(), 0);
      check("final_errs_left", err_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Receive-side framing stage placed directly downstream of the UART receiver. It takes the receiver's byte and done-tick outputs and finds frames of the form SYNC, LEN, payload, CHK. It buffers the payload and checks an XOR checksum. Only frames that pass the checksum are released, one byte per beat, on a valid/ready stream with a last marker; every rejected frame is reported with an error code.

## Interface
- `MAX_LEN`, default 16: maximum payload length in bytes. Legal range 1..255.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1000: number of idle clocks allowed between bytes inside a frame. 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock domain; reset is asynchronous and active-high.
- `rx_data_i`  in  8  received byte. Qualified by `rx_valid_i`.
- `rx_valid_i`  in  1  single-cycle byte tick from the receiver.
- `m_data_o`  out  8  payload byte.
- `m_valid_o`  out  1  payload byte available.
- `m_ready_i`  in  1  downstream accepts the byte.
- `m_last_o`  out  1  current byte is the final payload byte of the frame.
- `frame_ok_o`  out  1  one-cycle pulse: frame accepted.
- `frame_err_o`  out  1  one-cycle pulse: error event.
- `err_code_o`  out  2  code of the most recent error, held until the next error. 0 timeout, 1 length, 2 checksum, 3 overrun.
- `busy_o`  out  1  high whenever the state is not S_SYNC.

## Operation
- States: S_SYNC, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN. Every action on input bytes happens only on cycles with `rx_valid_i`=1.
- S_SYNC:
  - Byte == `SYNC_BYTE` → S_LEN. Any other byte is dropped silently.
- S_LEN, on a byte:
  - Byte is 0 or greater than `MAX_LEN` → length error (code 1), go to S_SYNC. The rejected byte is not re-examined as a sync byte.
  - Otherwise store `len`, set `acc`=byte, set `wr_idx`=0, go to S_PAYLOAD.
- S_PAYLOAD, on a byte:
  - Write `buf[wr_idx]`, set `acc` ^= byte, increment `wr_idx`.
  - On the byte with `wr_idx`==`len`-1 → S_CHK.
  - A `SYNC_BYTE` value is ordinary data here.
- S_CHK, on a byte:
  - Byte == `acc` (XOR of LEN and all payload bytes) → pulse `frame_ok_o`, set `rd_idx`=0, go to S_DRAIN.
  - Otherwise → checksum error (code 2), go to S_SYNC.
- S_DRAIN:
  - `m_valid_o`=1, `m_data_o`=`buf[rd_idx]`, `m_last_o`=(`rd_idx`==`len`-1).
  - On `m_valid_o` && `m_ready_i`, increment `rd_idx`. Accepting the last byte → S_SYNC.
  - Any byte arriving during S_DRAIN is dropped with an overrun error (code 3), one pulse per dropped byte. The state stays S_DRAIN.
- Timeout, active in S_LEN, S_PAYLOAD and S_CHK:
  - `tmo_cnt` clears on entry to S_LEN and on every byte, and increments on every cycle without a byte.
  - When `tmo_cnt` reaches `TIMEOUT_CYCLES`-1 on a cycle without a byte → timeout error (code 0), go to S_SYNC.
  - If a byte and timeout expiry coincide, the byte wins.
  - The counter is at least 16 bits wide. `TIMEOUT_CYCLES`=0 disables the timeout.
- Error event: `frame_err_o` pulses and `err_code_o` is updated at the same edge. A partially received payload is discarded.

## Timing
- Reset values: state S_SYNC, all indices/`acc`/`tmo_cnt` = 0, `m_valid_o`=0, `m_last_o`=0, `frame_ok_o`=0, `frame_err_o`=0, `err_code_o`=0, `busy_o`=0. `m_data_o` is 0 because `buf` is cleared.
- Every output is driven from registers or from state. The only combinational path is `m_data_o` = `buf[rd_idx]`; there is no combinational path from input to output.
- CHK tick at cycle N → `frame_ok_o`=1 and `m_valid_o`=1 at cycle N+1. With `m_ready_i` held high, an L-byte payload streams on cycles N+1 .. N+L.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_last_o` hold stable.
- Error tick at cycle N → `frame_err_o` high for exactly cycle N+1.
- Bytes can arrive every cycle; the parser takes one byte per cycle in every state.
- Reset asserted mid-frame or mid-drain clears everything immediately (asynchronously). The frame is lost and no pulse is generated.

## Test plan
- Send A5 03 11 22 33 03 with ready=1 → `frame_ok_o` pulses once; stream is 11, 22, 33 on three consecutive cycles; `m_last_o` is high only with 33.
- Same frame with `m_ready_i` toggling 1,0,0,1,… → each byte is held stable while stalled; exactly 3 handshakes, last on 33; `busy_o` falls the cycle after the last handshake.
- Send 00 FF A5 02 AA 55 FE (correct CHK would be FD) → `frame_err_o` pulse, `err_code_o`=2, `m_valid_o` never rises. Then send A5 01 5A 5B → 5A delivered with last.
- Send A5 00, then A5 11 with `MAX_LEN`=16 → two errors with code 1. Then send A5 01 A5 A4 → payload A5 delivered (sync value accepted as data).
- Send A5 02 10, then hold `rx_valid_i` low for 1000 cycles → error code 0 exactly 1000 cycles after the 10 tick (plus one registered cycle); next valid frame parses normally.
- With the frame from the first scenario in S_DRAIN and ready=0, inject byte 77 → error code 3, drain continues unaffected. Assert `rst_i` mid-payload of a new frame → all outputs return to reset values at once; the following frame is received correctly.
